// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: keypad matrix lines, entry clear and decoded-key outputs.
// slave is the scanner side, master is the keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry_value;

    modport slave (
        input  row,
        input  clr,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output entry_value
    );

    modport master (
        output row,
        output clr,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  entry_value
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, sample-based press/release debounce,
// hex decode and a four-digit shift register of accepted keys.
module keypad_scanner #(
    parameter int unsigned CPC        = 25000,
    parameter int unsigned DB_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.slave  kp
);

    localparam int unsigned CntW = (CPC > 1) ? $clog2(CPC) : 1;
    localparam int unsigned DbW  = $clog2(DB_SAMPLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CPC - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_SAMPLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

    state_e          state_q, state_d;
    logic [3:0]      row_meta_q, srow_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      col_q, col_d;
    logic [1:0]      cand_q, cand_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic [15:0]     entry_q;
    logic            sample;
    logic            accept;
    logic [1:0]      low_row;
    logic [3:0]      new_code;

    function automatic logic [3:0] key_map(logic [1:0] r, logic [1:0] c);
        logic [3:0] code;
        unique case ({r, c})
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'h0;
            4'd13: code = 4'hF;
            4'd14: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign sample   = (cnt_q == CntLast);
    assign new_code = key_map(cand_q, col_q);

    // Lowest row index wins when several keys share the driven column.
    always_comb begin
        low_row = 2'd3;
        if (!srow_q[0])      low_row = 2'd0;
        else if (!srow_q[1]) low_row = 2'd1;
        else if (!srow_q[2]) low_row = 2'd2;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        accept   = 1'b0;
        unique case (state_q)
            StScan: begin
                if (sample) begin
                    if (srow_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        cand_d   = low_row;
                        db_cnt_d = DbW'(1);
                        state_d  = StDebounce;
                    end
                end
            end
            StDebounce: begin
                if (sample) begin
                    if (!srow_q[cand_q]) begin
                        if (db_cnt_q >= DbLast) begin
                            state_d = StPressed;
                            accept  = 1'b1;
                        end else begin
                            db_cnt_d = db_cnt_q + DbW'(1);
                        end
                    end else begin
                        state_d = StScan;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            StPressed: begin
                if (sample && srow_q[cand_q]) begin
                    db_cnt_d = DbW'(1);
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                if (sample) begin
                    if (srow_q[cand_q]) begin
                        if (db_cnt_q >= DbLast) begin
                            state_d = StScan;
                            col_d   = col_q + 2'd1;
                        end else begin
                            db_cnt_d = db_cnt_q + DbW'(1);
                        end
                    end else begin
                        state_d = StPressed;
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            srow_q      <= 4'hF;
            cnt_q       <= '0;
            state_q     <= StScan;
            col_q       <= 2'd0;
            cand_q      <= 2'd0;
            db_cnt_q    <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            entry_q     <= 16'h0000;
        end else begin
            row_meta_q  <= kp.row;
            srow_q      <= row_meta_q;
            cnt_q       <= sample ? '0 : cnt_q + CntW'(1);
            state_q     <= state_d;
            col_q       <= col_d;
            cand_q      <= cand_d;
            db_cnt_q    <= db_cnt_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= new_code;
            end
            // Clear takes priority over shifting in a newly accepted key.
            if (kp.clr) begin
                entry_q <= 16'h0000;
            end else if (accept) begin
                entry_q <= {entry_q[11:0], new_code};
            end
        end
    end

    assign kp.col         = ~(4'b0001 << col_q);
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_held    = (state_q == StPressed) || (state_q == StRelease);
    assign kp.entry_value = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (CPC=4, DB_SAMPLES=3) with a behavioural keypad matrix
// that pulls a row low when a pressed key sits on the currently driven column.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] mask;
    int          n_cmp;
    int          n_err;
    int          vcount;
    int          vc0;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .CPC        (4),
        .DB_SAMPLES (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    function automatic logic [3:0] model_row(logic [15:0] m, logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (m[i*4+j] && !c[j]) r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    assign kp.row = model_row(mask, kp.col);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) vcount++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        while (kp.key_valid !== 1'b1 && i < 300) begin
            step(1);
            i++;
        end
        check({tag, "_valid"}, {15'd0, kp.key_valid}, 16'd1);
    endtask

    task automatic wait_released(input string tag);
        int i;
        i = 0;
        mask = 16'h0000;
        while (kp.key_held !== 1'b0 && i < 100) begin
            step(1);
            i++;
        end
        check({tag, "_released"}, {15'd0, kp.key_held}, 16'd0);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int i;
        i = 0;
        while (kp.col === target && i < 100) begin
            step(1);
            i++;
        end
        i = 0;
        while (kp.col !== target && i < 100) begin
            step(1);
            i++;
        end
        check("col_reached", {12'd0, kp.col}, {12'd0, target});
    endtask

    task automatic press_key(input int idx, input string tag);
        mask = 16'h0000;
        mask[idx] = 1'b1;
        wait_valid(tag);
        wait_released(tag);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        vcount = 0;
        mask   = 16'h0000;
        kp.clr = 1'b0;
        rst_n  = 1'b0;
        #22;
        check("rst_col", {12'd0, kp.col}, 16'h000E);
        check("rst_code", {12'd0, kp.key_code}, 16'h0000);
        check("rst_valid", {15'd0, kp.key_valid}, 16'h0000);
        check("rst_held", {15'd0, kp.key_held}, 16'h0000);
        check("rst_entry", kp.entry_value, 16'h0000);

        // Idle scan: each column is driven for four cycles.
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_n0", {12'd0, kp.col}, 16'h000E);
        step(3);
        check("idle_n3", {12'd0, kp.col}, 16'h000E);
        step(1);
        check("idle_n4", {12'd0, kp.col}, 16'h000D);
        step(4);
        check("idle_n8", {12'd0, kp.col}, 16'h000B);
        step(4);
        check("idle_n12", {12'd0, kp.col}, 16'h0007);
        step(4);
        check("idle_n16", {12'd0, kp.col}, 16'h000E);
        step(20);
        check("idle_novalid", 16'(vcount), 16'd0);

        // Key 6 held steady, then released.
        vc0 = vcount;
        mask = 16'h0000;
        mask[6] = 1'b1;
        wait_valid("k6");
        check("k6_code", {12'd0, kp.key_code}, 16'h0006);
        check("k6_entry", kp.entry_value, 16'h0006);
        check("k6_held", {15'd0, kp.key_held}, 16'd1);
        check("k6_col", {12'd0, kp.col}, 16'h000B);
        step(40);
        check("k6_single", 16'(vcount - vc0), 16'd1);
        check("k6_col_hold", {12'd0, kp.col}, 16'h000B);
        mask = 16'h0000;
        step(4);
        check("k6_held_rel", {15'd0, kp.key_held}, 16'd1);
        step(20);
        check("k6_held_clr", {15'd0, kp.key_held}, 16'd0);
        check("k6_code_keep", {12'd0, kp.key_code}, 16'h0006);

        // Sequence 1, 2, 3, A then B.
        press_key(0, "k1");
        press_key(1, "k2");
        press_key(2, "k3");
        press_key(3, "kA");
        check("seq_entry", kp.entry_value, 16'h123A);
        check("seq_code", {12'd0, kp.key_code}, 16'h000A);
        press_key(7, "kB");
        check("seq_entry_b", kp.entry_value, 16'h23AB);

        // Bounce on key 5: low for exactly one sample.
        vc0 = vcount;
        wait_col(4'b1101);
        mask = 16'h0000;
        mask[5] = 1'b1;
        step(5);
        check("bnc_col_hold", {12'd0, kp.col}, 16'h000D);
        mask = 16'h0000;
        step(3);
        check("bnc_col_next", {12'd0, kp.col}, 16'h000B);
        step(20);
        check("bnc_novalid", 16'(vcount - vc0), 16'd0);
        check("bnc_entry", kp.entry_value, 16'h23AB);

        // Key 9 with a one-sample release glitch.
        vc0 = vcount;
        mask = 16'h0000;
        mask[10] = 1'b1;
        wait_valid("k9");
        step(5);
        mask = 16'h0000;
        step(4);
        mask[10] = 1'b1;
        check("gl_held_mid", {15'd0, kp.key_held}, 16'd1);
        step(20);
        check("gl_held", {15'd0, kp.key_held}, 16'd1);
        check("gl_col", {12'd0, kp.col}, 16'h000B);
        check("gl_single", 16'(vcount - vc0), 16'd1);
        check("gl_entry", kp.entry_value, 16'h3AB9);
        wait_released("k9");

        // Keys 5 and 8 together on column 1: row 1 wins.
        mask = 16'h0000;
        mask[5] = 1'b1;
        mask[9] = 1'b1;
        wait_valid("k58");
        check("multi_code", {12'd0, kp.key_code}, 16'h0005);
        check("multi_entry", kp.entry_value, 16'hAB95);
        wait_released("k58");

        // Clear coincident with acceptance of key F.
        kp.clr = 1'b1;
        mask = 16'h0000;
        mask[13] = 1'b1;
        wait_valid("kF");
        kp.clr = 1'b0;
        check("clr_entry", kp.entry_value, 16'h0000);
        check("clr_code", {12'd0, kp.key_code}, 16'h000F);
        wait_released("kF");

        // Reset while debouncing key 2.
        vc0 = vcount;
        wait_col(4'b1101);
        mask = 16'h0000;
        mask[1] = 1'b1;
        step(6);
        rst_n = 1'b0;
        #1;
        check("mrst_col", {12'd0, kp.col}, 16'h000E);
        check("mrst_code", {12'd0, kp.key_code}, 16'h0000);
        check("mrst_valid", {15'd0, kp.key_valid}, 16'h0000);
        check("mrst_held", {15'd0, kp.key_held}, 16'h0000);
        check("mrst_entry", kp.entry_value, 16'h0000);
        mask = 16'h0000;
        step(3);
        rst_n = 1'b1;
        check("mrst_col_after", {12'd0, kp.col}, 16'h000E);
        step(40);
        check("mrst_novalid", 16'(vcount - vc0), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
- REQ-001: Parameter CPC, default 25000; clock cycles each column is driven before its rows are sampled (0.25 ms at 100 MHz).
- REQ-002: Parameter DB_SAMPLES, default 8; consecutive agreeing samples required to accept a press or a release.
- REQ-003: clk  input  1  system clock; the block has this one clock only.
- REQ-004: rst_n  input  1  asynchronous active-low reset.
- REQ-005: row  input  4  keypad rows, active low, pulled up, asynchronous to clk; row[0] is the top row.
- REQ-006: clr  input  1  synchronous clear of entry_value, active high.
- REQ-007: col  output  4  column drive, active low, exactly one bit low at any time; col[0] is the leftmost column.
- REQ-008: key_code  output  4  hex code of the last accepted key.
- REQ-009: key_valid  output  1  one-cycle pulse when a key is accepted.
- REQ-010: key_held  output  1  high while the accepted key remains pressed.
- REQ-011: entry_value  output  16  last four accepted key codes, newest in [3:0]; connects directly to the 16-bit input of the display driver.

Function
- REQ-012: row SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized row value (srow).
- REQ-013: Key map [row][col] SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D.
- REQ-014: A dwell counter SHALL count 0..CPC-1 and wrap; a sample point occurs on the cycle where counter == CPC-1.
- REQ-015: The state machine SHALL have exactly four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- REQ-016: SCAN behaviour:
  - At a sample point with srow == 4'hF, col SHALL advance 0→1→2→3→0.
  - At a sample point with any srow bit low, the block SHALL latch the current column and the lowest-index low row as the candidate, then move to DEBOUNCE with good-count = 1.
- REQ-017: DEBOUNCE behaviour:
  - col SHALL be held.
  - At each sample point with the candidate row low, good-count SHALL increment.
  - When good-count reaches DB_SAMPLES, the block SHALL move to PRESSED.
  - At a sample point with the candidate row high, the block SHALL return to SCAN and advance col.
- REQ-018: On the cycle after entering PRESSED:
  - key_valid SHALL be 1 for exactly one cycle.
  - key_code SHALL update to the candidate's map value.
  - entry_value SHALL become {entry_value[11:0], key_code_new}.
- REQ-019: PRESSED behaviour:
  - key_held SHALL be 1 and col SHALL be held.
  - At a sample point with the candidate row high, the block SHALL move to RELEASE with release-count = 1.
  - Other rows going low SHALL be ignored.
- REQ-020: RELEASE behaviour:
  - key_held SHALL stay 1.
  - At each sample point with the candidate row high, release-count SHALL increment.
  - When release-count reaches DB_SAMPLES, the block SHALL clear key_held, return to SCAN and advance col.
  - At a sample point with the candidate row low, the block SHALL return to PRESSED with no new key_valid.
- REQ-021: Multiple keys on one column: the lowest row index SHALL win; keys on other columns SHALL be invisible until SCAN resumes.
- REQ-022: If clr and key_valid occur in the same cycle, clr SHALL win: entry_value = 16'h0000, while key_code and key_valid still update.
- REQ-023: With DB_SAMPLES = 1, DEBOUNCE SHALL be exited at its first sample point, i.e. after the SCAN sample plus one further agreeing sample.
- REQ-024: key_code SHALL retain its value until the next accepted key.

Reset
- REQ-025: While rst_n = 0 the outputs SHALL be: col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, entry_value = 16'h0000.
- REQ-026: While rst_n = 0 the internals SHALL be: state SCAN, all counters 0, synchronizer flops = 4'hF.
- REQ-027: Reset asserted mid-debounce or mid-press SHALL abort without any key_valid; after release of reset, scanning SHALL restart at col 0.

Verification (CPC = 4, DB_SAMPLES = 3)
- REQ-028: No key pressed → col cycles 1110, 1101, 1011, 0111, holding each for 4 cycles; key_valid never asserts.
- REQ-029: Key "6" (row1, col2) held steady → exactly one key_valid; key_code = 4'h6; entry_value = 16'h0006; key_held = 1 until 3 high samples after release.
- REQ-030: Sequence 1, 2, 3, A, then B → entry_value = 16'h123A, then 16'h23AB.
- REQ-031: Bouncing press, row low for 1 sample then high → no key_valid; SCAN resumes at the next column.
- REQ-032: Release glitch (one high sample during PRESSED, then low again) → return to PRESSED, no second key_valid.
- REQ-033: clr asserted in the key_valid cycle for key "F" → entry_value = 0 and key_code = 4'hF; a later rst_n pulse during DEBOUNCE → all outputs at reset values and col = 4'b1110.
